// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - plays fixed jingles from an internal ROM on the buzzer note/enable interface
module melody_sequencer #(
  parameter int UNIT_CLKS = 1250000,
  parameter int GAP_CLKS  = 125000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] song_sel,
  input  logic       stop,
  output logic [3:0] note,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  localparam int UW = $clog2(UNIT_CLKS + 1);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  state_t          state;
  logic [4:0]      addr;
  logic [UW-1:0]   unit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      units_left;
  logic [6:0]      entry;
  logic [3:0]      entry_note;
  logic [2:0]      entry_dur;

  // Each entry is {note, dur}; dur == 0 marks the end of a song.
  function automatic logic [6:0] rom_entry(input logic [4:0] a);
    case (a)
      5'd0:    rom_entry = {4'd1, 3'd2};
      5'd1:    rom_entry = {4'd3, 3'd2};
      5'd2:    rom_entry = {4'd5, 3'd2};
      5'd3:    rom_entry = {4'd7, 3'd4};
      5'd8:    rom_entry = {4'd8, 3'd1};
      5'd16:   rom_entry = {4'd9, 3'd4};
      5'd17:   rom_entry = {4'd0, 3'd2};
      5'd18:   rom_entry = {4'd10, 3'd6};
      5'd24:   rom_entry = {4'd10, 3'd1};
      5'd25:   rom_entry = {4'd0, 3'd1};
      5'd26:   rom_entry = {4'd10, 3'd1};
      default: rom_entry = 7'd0;
    endcase
  endfunction

  assign entry      = rom_entry(addr);
  assign entry_note = entry[6:3];
  assign entry_dur  = entry[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      unit_cnt   <= '0;
      gap_cnt    <= '0;
      units_left <= '0;
      note       <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (stop && state != IDLE) begin
      state  <= IDLE;
      note   <= '0;
      enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          note   <= '0;
          enable <= 1'b0;
          busy   <= 1'b0;
          if (start && !stop) begin
            addr  <= {song_sel, 3'b000};
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (entry_dur == 3'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            units_left <= entry_dur;
            unit_cnt   <= '0;
            note       <= entry_note;
            enable     <= (entry_note != 4'd0);
            state      <= PLAY;
          end
        end
        PLAY: begin
          if (unit_cnt == UNIT_LAST) begin
            unit_cnt <= '0;
            if (units_left == 3'd1) begin
              note    <= '0;
              enable  <= 1'b0;
              addr    <= addr + 5'd1;
              gap_cnt <= '0;
              state   <= (GAP_CLKS > 0) ? GAP : LOAD;
            end else begin
              units_left <= units_left - 3'd1;
            end
          end else begin
            unit_cnt <= unit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - cycle-trace scoreboard bench for melody_sequencer (UNIT_CLKS=4, GAP_CLKS=2)
module tb_melody_sequencer;

  localparam int UNIT = 4;
  localparam int GAPC = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] song_sel;
  logic       stop;
  logic [3:0] note;
  logic       enable;
  logic       busy;
  logic       done;

  melody_sequencer #(.UNIT_CLKS(UNIT), .GAP_CLKS(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .song_sel(song_sel), .stop(stop),
    .note(note), .enable(enable), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation word {note, enable, busy, done}
  typedef logic [6:0] obs_t;

  typedef struct {
    logic [1:0] song;
    int         poke;
    int         exp_busy;
    int         exp_en;
    int         exp_done;
  } vec_t;

  int snote [4][5] = '{'{1, 3, 5, 7, 0}, '{8, 0, 0, 0, 0}, '{9, 0, 10, 0, 0}, '{10, 0, 10, 0, 0}};
  int sdur  [4][5] = '{'{2, 2, 2, 4, 0}, '{1, 0, 0, 0, 0}, '{4, 2, 6, 0, 0}, '{1, 1, 1, 0, 0}};

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    return {note, enable, busy, done};
  endfunction

  // Expected per-cycle trace starting with the LOAD cycle after start is accepted.
  task automatic build(input int s);
    exp_q.delete();
    exp_q.push_back({4'd0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      if (sdur[s][i] == 0) break;
      for (int c = 0; c < sdur[s][i] * UNIT; c++)
        exp_q.push_back({4'(snote[s][i]), (snote[s][i] != 0), 1'b1, 1'b0});
      for (int c = 0; c < GAPC + 1; c++)
        exp_q.push_back({4'd0, 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back({4'd0, 1'b0, 1'b1, 1'b1});
    exp_q.push_back({4'd0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic play(input logic [1:0] s, input int poke,
                      output int nbusy, output int nen, output int ndone);
    obs_t o, e;
    int   idx;
    nbusy = 0; nen = 0; ndone = 0; idx = 0;
    build(s);
    @(negedge clk); start = 1'b1; song_sel = s;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      o = sample();
      e = exp_q.pop_front();
      check($sformatf("trace s%0d i%0d", s, idx), o, e);
      nbusy += o[1]; nen += o[2]; ndone += o[0];
      if (idx == 0) begin start = 1'b0; song_sel = s + 2'd1; end
      if (idx == poke) begin start = 1'b1; song_sel = s ^ 2'd1; end
      else if (idx == poke + 1) start = 1'b0;
      idx++;
    end
    start = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    int nb, ne, nd;
    obs_t o;
    vecs[0] = '{song: 2'd1, poke: -10, exp_busy: 9,  exp_en: 4,  exp_done: 1};
    vecs[1] = '{song: 2'd0, poke: -10, exp_busy: 54, exp_en: 40, exp_done: 1};
    vecs[2] = '{song: 2'd2, poke: -10, exp_busy: 59, exp_en: 40, exp_done: 1};
    vecs[3] = '{song: 2'd3, poke: -10, exp_busy: 23, exp_en: 8,  exp_done: 1};
    vecs[4] = '{song: 2'd1, poke: 3,   exp_busy: 9,  exp_en: 4,  exp_done: 1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; song_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("reset_idle c%0d", c), sample(), 7'd0);
    end

    // Stop during the second note of song0: immediate idle, no done pulse.
    build(0);
    @(negedge clk); start = 1'b1; song_sel = 2'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      check($sformatf("stop_trace i%0d", i), sample(), exp_q.pop_front());
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_idle", sample(), 7'd0);
    exp_q.delete();
    nd = 0; nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nd += done; nb += busy;
    end
    check("stop_no_done", nd, 0);
    check("stop_no_busy", nb, 0);

    for (int v = 0; v < 5; v++) begin
      play(vecs[v].song, vecs[v].poke, nb, ne, nd);
      check($sformatf("vec%0d busy_cycles", v), nb, vecs[v].exp_busy);
      check($sformatf("vec%0d enable_cycles", v), ne, vecs[v].exp_en);
      check($sformatf("vec%0d done_pulses", v), nd, vecs[v].exp_done);
    end

    // start and stop together in IDLE: stop wins.
    @(negedge clk); start = 1'b1; stop = 1'b1; song_sel = 2'd1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("start_stop_idle c%0d", c), sample(), 7'd0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a note.
    @(negedge clk); start = 1'b1; song_sel = 2'd2;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_note", {note, enable, busy}, {4'd9, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1 o = sample();
    check("async_reset_outputs", o, 7'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0; nb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nd += done; nb += busy;
    end
    check("reset_no_done", nd, 0);
    check("reset_no_busy", nb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
